// File: rtl/i2c_target_regs.sv
// I2C target answering one 7-bit address, fronting a DEPTH-byte register file.
// SCL/SDA are synchronized into clk; every bus event comes from the synchronized levels.
`timescale 1ns/1ps
module i2c_target_regs #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    localparam int        PW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          scl,
    input  logic          sda_in,
    output logic          sda_oe,
    output logic          busy,
    output logic          wr_stb,
    output logic [PW-1:0] wr_addr,
    output logic [7:0]    wr_data
);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RD_ACK, WAIT_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          acked_q, acked_d;
    logic          sda_oe_q, sda_oe_d;
    logic          busy_q, busy_d;
    logic          wr_stb_q, wr_stb_d;
    logic [PW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [7:0]    regs_q [DEPTH];

    logic scl_s1_q, scl_s2_q, scl_d1_q;
    logic sda_s1_q, sda_s2_q, sda_d1_q;
    logic scl_rise_s, scl_fall_s, start_s, stop_s;

    // Two-flop synchronizers plus one edge-detect stage; reset to the idle-bus level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_d1_q <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_d1_q <= 1'b1;
        end else begin
            scl_s1_q <= scl;
            scl_s2_q <= scl_s1_q;
            scl_d1_q <= scl_s2_q;
            sda_s1_q <= sda_in;
            sda_s2_q <= sda_s1_q;
            sda_d1_q <= sda_s2_q;
        end
    end

    assign scl_rise_s = scl_s2_q & ~scl_d1_q;
    assign scl_fall_s = ~scl_s2_q & scl_d1_q;
    assign start_s    = scl_s2_q & scl_d1_q & sda_d1_q & ~sda_s2_q;
    assign stop_s     = scl_s2_q & scl_d1_q & ~sda_d1_q & sda_s2_q;

    // Next-state and output decode; START/STOP win over any SCL edge in the same clk.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sh_d      = sh_q;
        ptr_d     = ptr_q;
        acked_d   = acked_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_stb_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (stop_s) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = 4'd0;
        end else if (start_s) begin
            state_d  = ADDR;
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR, PTR, WDATA: begin
                    if (scl_rise_s) begin
                        sh_d  = {sh_q[6:0], sda_s2_q};
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall_s && (cnt_q == 4'd8)) begin
                        sda_oe_d = 1'b1;
                        if (state_q == ADDR) begin
                            if (sh_q[7:1] == DEV_ADDR) begin
                                state_d = ADDR_ACK;
                                busy_d  = 1'b1;
                            end else begin
                                state_d  = WAIT_STOP;
                                sda_oe_d = 1'b0;
                            end
                        end else if (state_q == PTR) begin
                            state_d = PTR_ACK;
                            ptr_d   = sh_q[PW-1:0];
                        end else begin
                            state_d   = WDATA_ACK;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = sh_q;
                            ptr_d     = ptr_q + PW'(1);
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall_s) begin
                        if (sh_q[0]) begin
                            state_d  = RDATA;
                            sh_d     = regs_q[ptr_q];
                            sda_oe_d = ~regs_q[ptr_q][7];
                            cnt_d    = 4'd1;
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                            cnt_d    = 4'd0;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall_s) begin
                        state_d  = WDATA;
                        sda_oe_d = 1'b0;
                        cnt_d    = 4'd0;
                    end else begin
                        state_d = state_q;
                    end
                end
                RDATA: begin
                    if (scl_fall_s) begin
                        if (cnt_q == 4'd8) begin
                            state_d  = RD_ACK;
                            sda_oe_d = 1'b0;
                            acked_d  = 1'b0;
                        end else begin
                            sh_d     = {sh_q[6:0], 1'b0};
                            sda_oe_d = ~sh_q[6];
                            cnt_d    = cnt_q + 4'd1;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                RD_ACK: begin
                    if (scl_rise_s) begin
                        ptr_d = ptr_q + PW'(1);
                        if (!sda_s2_q) begin
                            acked_d = 1'b1;
                        end else begin
                            state_d = WAIT_STOP;
                        end
                    end else if (scl_fall_s && acked_q) begin
                        state_d  = RDATA;
                        sh_d     = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                        cnt_d    = 4'd1;
                        acked_d  = 1'b0;
                    end else begin
                        state_d = state_q;
                    end
                end
                WAIT_STOP: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            sh_q      <= 8'h00;
            ptr_q     <= '0;
            acked_q   <= 1'b0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sh_q      <= sh_d;
            ptr_q     <= ptr_d;
            acked_q   <= acked_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_stb_q  <= wr_stb_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Register file, written on the same edge that raises wr_stb.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_stb_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end else begin
            regs_q <= regs_q;
        end
    end

    assign sda_oe  = sda_oe_q;
    assign busy    = busy_q;
    assign wr_stb  = wr_stb_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C controller plus a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_c = 1'b1;
    logic       sda_c = 1'b1;
    logic       sda_line;
    logic       sda_oe, busy, wr_stb;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;

    int errors = 0;
    int checks = 0;

    logic [7:0]  m_regs [16];
    logic [3:0]  m_ptr = 4'd0;
    logic [11:0] expq [$];
    logic        exp_oe = 1'b0;
    logic        exp_busy = 1'b0;
    logic        chk_on = 1'b0;
    logic [7:0]  wbuf [4];
    logic [7:0]  rbuf [4];

    assign sda_line = sda_c & ~sda_oe;

    i2c_target_regs #(.DEV_ADDR(7'h50), .DEPTH(16)) dut (
        .clk(clk), .rst(rst_n), .scl(scl_c), .sda_in(sda_line),
        .sda_oe(sda_oe), .busy(busy), .wr_stb(wr_stb),
        .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare: SDA drive and busy during SCL high phases, every write strobe against the model queue.
    always @(negedge clk) begin
        logic [11:0] e;
        if (chk_on) begin
            chk("sda_oe", {31'd0, sda_oe}, {31'd0, exp_oe});
            chk("busy", {31'd0, busy}, {31'd0, exp_busy});
        end
        if (wr_stb) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stb_unexpected: got write addr=%0d data=0x%0h expected no write", wr_addr, wr_data);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", {28'd0, wr_addr}, {28'd0, e[11:8]});
                chk("wr_data", {24'd0, wr_data}, {24'd0, e[7:0]});
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
        m_ptr    = 4'd0;
        exp_busy = 1'b0;
        expq.delete();
    endtask

    task automatic bit_x(input logic b, input logic eo, output logic r);
        repeat (6) @(negedge clk);
        sda_c = b;
        repeat (6) @(negedge clk);
        scl_c  = 1'b1;
        exp_oe = eo;
        chk_on = 1'b1;
        repeat (6) @(negedge clk);
        r = sda_line;
        repeat (6) @(negedge clk);
        chk_on = 1'b0;
        scl_c  = 1'b0;
    endtask

    task automatic do_start();
        repeat (6) @(negedge clk);
        sda_c = 1'b1;
        repeat (6) @(negedge clk);
        scl_c = 1'b1;
        repeat (6) @(negedge clk);
        sda_c = 1'b0;
        repeat (6) @(negedge clk);
        scl_c = 1'b0;
    endtask

    task automatic do_stop();
        repeat (6) @(negedge clk);
        sda_c = 1'b0;
        repeat (6) @(negedge clk);
        scl_c = 1'b1;
        repeat (6) @(negedge clk);
        sda_c = 1'b1;
        repeat (12) @(negedge clk);
        exp_busy = 1'b0;
        chk("busy_after_stop", {31'd0, busy}, 32'd0);
        chk("oe_after_stop", {31'd0, sda_oe}, 32'd0);
        chk("stb_missing", expq.size(), 32'd0);
    endtask

    task automatic send8(input logic [7:0] v);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(v[i], 1'b0, r);
    endtask

    task automatic ack9(input logic exp_ack);
        logic r;
        bit_x(1'b1, exp_ack, r);
        chk("ack_line", {31'd0, ~r}, {31'd0, exp_ack});
    endtask

    task automatic wr_txn(input logic [6:0] a, input logic [7:0] p, input int n, input logic stop_now);
        logic match;
        match = (a == 7'h50);
        do_start();
        send8({a, 1'b0});
        if (match) exp_busy = 1'b1;
        ack9(match);
        send8(p);
        if (match) m_ptr = p[3:0];
        ack9(match);
        for (int k = 0; k < n; k++) begin
            send8(wbuf[k]);
            if (match) begin
                m_regs[m_ptr] = wbuf[k];
                expq.push_back({m_ptr, wbuf[k]});
                m_ptr = m_ptr + 4'd1;
            end
            ack9(match);
        end
        if (stop_now) do_stop();
    endtask

    task automatic rd_txn(input int n);
        logic [7:0] e, got;
        logic       r;
        do_start();
        send8({7'h50, 1'b1});
        exp_busy = 1'b1;
        ack9(1'b1);
        for (int k = 0; k < n; k++) begin
            e = m_regs[m_ptr];
            for (int i = 7; i >= 0; i--) begin
                bit_x(1'b1, ~e[i], r);
                got[i] = r;
            end
            chk("rd_byte", {24'd0, got}, {24'd0, e});
            rbuf[k] = got;
            bit_x((k == n - 1) ? 1'b1 : 1'b0, 1'b0, r);
            m_ptr = m_ptr + 4'd1;
        end
        do_stop();
    endtask

    initial begin
        logic r;
        int   kind, n, nb;
        logic [7:0] p, v;
        logic [6:0] a;
        model_reset();

        // Reset state
        repeat (4) @(negedge clk);
        chk("rst_oe", {31'd0, sda_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stb", {31'd0, wr_stb}, 32'd0);
        chk("rst_wr_addr", {28'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Reset in the middle of a read bit
        wbuf[0] = 8'h77;
        wr_txn(7'h50, 8'h00, 1, 1'b1);
        do_start();
        send8(8'hA1);
        exp_busy = 1'b1;
        ack9(1'b1);
        repeat (6) @(negedge clk);
        sda_c = 1'b1;
        repeat (6) @(negedge clk);
        scl_c = 1'b1;
        repeat (4) @(negedge clk);
        chk("rd_oe_before_rst", {31'd0, sda_oe}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_oe", {31'd0, sda_oe}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        scl_c = 1'b0;
        do_stop();
        rd_txn(1);
        chk("post_rst_read", {24'd0, rbuf[0]}, 32'h00);

        // Write burst and random read
        wbuf[0] = 8'h5A;
        wr_txn(7'h50, 8'h05, 1, 1'b1);
        wbuf[0] = 8'h11;
        wbuf[1] = 8'h22;
        wr_txn(7'h50, 8'h03, 2, 1'b1);
        wr_txn(7'h50, 8'h03, 0, 1'b0);
        rd_txn(2);
        chk("rnd_read0", {24'd0, rbuf[0]}, 32'h11);
        chk("rnd_read1", {24'd0, rbuf[1]}, 32'h22);
        chk("model_ptr5", {28'd0, m_ptr}, 32'd5);
        rd_txn(1);
        chk("cur_read_ptr5", {24'd0, rbuf[0]}, 32'h5A);

        // Pointer wrap and upper pointer bits ignored
        wbuf[0] = 8'hAA;
        wbuf[1] = 8'hBB;
        wr_txn(7'h50, 8'h0F, 2, 1'b1);
        wr_txn(7'h50, 8'h1F, 0, 1'b1);
        rd_txn(2);
        chk("wrap_read15", {24'd0, rbuf[0]}, 32'hAA);
        chk("wrap_read0", {24'd0, rbuf[1]}, 32'hBB);

        // Address mismatch, then a matching transaction
        wbuf[0] = 8'h12;
        wr_txn(7'h51, 8'h00, 1, 1'b1);
        wbuf[0] = 8'h3C;
        wr_txn(7'h50, 8'h07, 1, 1'b1);

        // Early STOP inside a data byte
        wr_txn(7'h50, 8'h03, 0, 1'b0);
        for (int i = 7; i >= 4; i--) bit_x(1'b0, 1'b0, r);
        do_stop();
        wr_txn(7'h50, 8'h03, 0, 1'b0);
        rd_txn(1);
        chk("early_stop_keep", {24'd0, rbuf[0]}, 32'h11);

        // Randomized transactions against the model
        for (int it = 0; it < 20; it++) begin
            kind = int'($urandom_range(0, 3));
            p    = 8'($urandom);
            case (kind)
                0: begin
                    n = int'($urandom_range(1, 3));
                    for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
                    a = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h50;
                    wr_txn(a, p, n, 1'b1);
                end
                1: begin
                    wr_txn(7'h50, p, 0, 1'b0);
                    rd_txn(int'($urandom_range(1, 3)));
                end
                2: rd_txn(int'($urandom_range(1, 3)));
                default: begin
                    nb = int'($urandom_range(1, 7));
                    v  = 8'($urandom);
                    wr_txn(7'h50, p, 0, 1'b0);
                    for (int i = 0; i < nb; i++) bit_x(v[i], 1'b0, r);
                    do_stop();
                end
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
